// File: rtl/alu_share_arb_if.sv
// Bundles the request, ALU-drive and response signals of alu_share_arb.
//   req0_* / req1_* : valid/ready request channels (op, operand a, operand b)
//   alu_*           : operands/opcode to the external ALU and its combinational result
//   rsp_*           : tagged valid/ready response channel
// slave  : the arbiter's view.  master : the surrounding environment's view.
interface alu_share_arb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 4
);
  logic            req0_valid;
  logic            req0_ready;
  logic [OPW-1:0]  req0_op;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;

  logic            req1_valid;
  logic            req1_ready;
  logic [OPW-1:0]  req1_op;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;

  logic [XLEN-1:0] alu_d1;
  logic [XLEN-1:0] alu_d2;
  logic [OPW-1:0]  alu_control;
  logic [XLEN-1:0] alu_result;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_id;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_d1, alu_d2, alu_control,
    input  alu_result,
    output rsp_valid, rsp_result, rsp_id,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_d1, alu_d2, alu_control,
    output alu_result,
    input  rsp_valid, rsp_result, rsp_id,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one external combinational ALU between two requesters,
// with the ALU result captured in a one-entry tagged response register.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_share_arb_if.slave (request channels, ALU drive, response channel)
module alu_share_arb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_share_arb_if.slave   bus
);

  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_result_q, rsp_result_d;
  logic            rsp_id_q, rsp_id_d;
  logic            last_grant_q, last_grant_d;

  logic            can_issue;
  logic            grant0, grant1;
  logic            ready0, ready1;
  logic            accept;

  // Output slot is free, or is being drained this same cycle.
  assign can_issue = !rsp_valid_q || bus.rsp_ready;

  // Round-robin grant: on contention the requester that did not win last goes.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant0 = last_grant_q;
      grant1 = !last_grant_q;
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
  end

  // Held low while in reset so nothing looks accepted that the registers ignore.
  assign ready0 = grant0 && can_issue && rst_n;
  assign ready1 = grant1 && can_issue && rst_n;
  assign accept = ready0 || ready1;

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;

  // Granted requester drives the ALU; idle cycles drive zeros.
  always_comb begin
    bus.alu_d1      = '0;
    bus.alu_d2      = '0;
    bus.alu_control = '0;
    if (grant0) begin
      bus.alu_d1      = bus.req0_a;
      bus.alu_d2      = bus.req0_b;
      bus.alu_control = bus.req0_op;
    end else if (grant1) begin
      bus.alu_d1      = bus.req1_a;
      bus.alu_d2      = bus.req1_b;
      bus.alu_control = bus.req1_op;
    end
  end

  // Response register and round-robin pointer next state.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = bus.alu_result;
      rsp_id_d     = ready1;
      last_grant_d = ready1;
    end else if (bus.rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_id     = rsp_id_q;

endmodule
